// File: rtl/syndrome_check_seq.sv
// Sequential LDPC syndrome checker: accumulates s = cw * H^T over GF(2), P columns per beat,
// and returns syndrome, its weight and a pass flag through valid/ready handshakes.
module syndrome_check_seq #(
   parameter int N = 204,
   parameter int K = 102,
   parameter int P = 4,
   localparam int M  = N - K,
   localparam int WW = $clog2(N - K + 1),
   localparam int B  = (N + P - 1) / P
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*M-1:0]   H_t,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     cw_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [M-1:0]     syndrome,
   output logic [WW-1:0]    syn_weight,
   output logic             cw_ok,
   output logic             busy
);

   localparam int CW = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    cw_q, cw_d;
   logic [M-1:0]    acc_q, acc_d;
   logic [M-1:0]    syn_q, syn_d;
   logic [WW-1:0]   wt_q, wt_d;
   logic            ok_q, ok_d;
   logic            ov_q, ov_d;

   logic [M-1:0]    trm [B][P];
   logic [M-1:0]    beat_x;
   logic [M-1:0]    acc_nx;

   // Masked H rows arranged per beat; slots past column N-1 are padding and contribute nothing.
   for (genvar b = 0; b < B; b++) begin : g_beat
      for (genvar p = 0; p < P; p++) begin : g_col
         if (b * P + p < N) begin : g_real
            assign trm[b][p] = H_t[(b*P+p)*M +: M] & {M{cw_q[b*P+p]}};
         end else begin : g_pad
            assign trm[b][p] = '0;
         end
      end
   end

   always_comb begin
      beat_x = '0;
      for (int unsigned p = 0; p < P; p++) begin
         beat_x = beat_x ^ trm[cnt_q][p];
      end
   end

   assign acc_nx = acc_q ^ beat_x;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cw_d    = cw_q;
      acc_d   = acc_q;
      syn_d   = syn_q;
      wt_d    = wt_q;
      ok_d    = ok_q;
      ov_d    = ov_q;
      if (flush) begin
         state_d = S_IDLE;
         ov_d    = 1'b0;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cw_d    = cw_in;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_ACC;
               end
            end
            S_ACC: begin
               acc_d = acc_nx;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(B - 1)) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
                  syn_d   = acc_nx;
                  wt_d    = WW'($countones(acc_nx));
                  ok_d    = (acc_nx == '0);
                  ov_d    = 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  ov_d    = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cw_q    <= '0;
         acc_q   <= '0;
         syn_q   <= '0;
         wt_q    <= '0;
         ok_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cw_q    <= cw_d;
         acc_q   <= acc_d;
         syn_q   <= syn_d;
         wt_q    <= wt_d;
         ok_q    <= ok_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign out_valid  = ov_q;
   assign syndrome   = syn_q;
   assign syn_weight = wt_q;
   assign cw_ok      = ok_q;

endmodule

// File: tb/tb_syndrome_check_seq.sv
// Bench for syndrome_check_seq: transaction-level model checked every cycle at the default
// size, plus directed literal checks including a small padded configuration.
module tb_syndrome_check_seq;

   localparam int N  = 204;
   localparam int K  = 102;
   localparam int P  = 4;
   localparam int M  = N - K;
   localparam int B  = 51;
   localparam int WW = 7;

   localparam int N2  = 6;
   localparam int K2  = 3;
   localparam int M2  = 3;
   localparam int WW2 = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [N*M-1:0] H = '0;
   logic           in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [N-1:0]   cw_in = '0;
   logic           in_ready, out_valid, cw_ok, busy;
   logic [M-1:0]   syndrome;
   logic [WW-1:0]  syn_weight;

   logic [N2*M2-1:0] H2 = {3'b111, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001};
   logic             in_valid2 = 1'b0, out_ready2 = 1'b0;
   logic [N2-1:0]    cw_in2 = '0;
   logic             in_ready2, out_valid2, cw_ok2, busy2;
   logic [M2-1:0]    syndrome2;
   logic [WW2-1:0]   syn_weight2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   syndrome_check_seq #(.N(N), .K(K), .P(P)) dut (
      .clk(clk), .rst_n(rst_n), .H_t(H), .in_valid(in_valid), .in_ready(in_ready),
      .cw_in(cw_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .syndrome(syndrome), .syn_weight(syn_weight), .cw_ok(cw_ok), .busy(busy)
   );

   syndrome_check_seq #(.N(N2), .K(K2), .P(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .H_t(H2), .in_valid(in_valid2), .in_ready(in_ready2),
      .cw_in(cw_in2), .flush(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
      .syndrome(syndrome2), .syn_weight(syn_weight2), .cw_ok(cw_ok2), .busy(busy2)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Each parity-check row evaluated directly: s[i] = XOR_j H[j][i] & cw[j].
   function automatic logic [M-1:0] model_syn(input logic [N-1:0] cw, input logic [N*M-1:0] h);
      logic [M-1:0] s;
      s = '0;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            s[i] = s[i] ^ (h[j*M+i] & cw[j]);
         end
      end
      return s;
   endfunction

   function automatic int popc(input logic [M-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < M; i++) c += int'(v[i]);
      return c;
   endfunction

   // Transaction model: an accepted word completes B edges later; results persist until replaced.
   logic         m_pend = 1'b0, m_valid = 1'b0, m_ok = 1'b0;
   int           m_left = 0;
   logic [M-1:0] m_pend_syn = '0, m_syn = '0;
   int           m_wt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = 1'b0; m_valid = 1'b0; m_syn = '0; m_wt = 0; m_ok = 1'b0; m_left = 0;
      end else if (flush) begin
         m_pend = 1'b0; m_valid = 1'b0;
      end else if (m_pend) begin
         m_left--;
         if (m_left == 0) begin
            m_pend  = 1'b0;
            m_valid = 1'b1;
            m_syn   = m_pend_syn;
            m_wt    = popc(m_pend_syn);
            m_ok    = (m_pend_syn == '0);
         end
      end else if (m_valid) begin
         if (out_ready) m_valid = 1'b0;
      end else if (in_valid) begin
         m_pend     = 1'b1;
         m_left     = B;
         m_pend_syn = model_syn(cw_in, H);
      end
   end

   always @(negedge clk) begin
      chk("out_valid", 128'(out_valid), 128'(m_valid));
      chk("in_ready", 128'(in_ready), 128'(!m_pend && !m_valid));
      chk("busy", 128'(busy), 128'(m_pend || m_valid));
      chk("syndrome", 128'(syndrome), 128'(m_syn));
      chk("syn_weight", 128'(syn_weight), 128'(m_wt));
      chk("cw_ok", 128'(cw_ok), 128'(m_ok));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] cw);
      cw_in    = cw;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm, output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      if (!out_valid) chk({nm, "_timeout"}, 128'(0), 128'(1));
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [N-1:0] encode(input logic [K-1:0] u);
      logic [M-1:0] a, p;
      logic [N-1:0] cw;
      for (int r = 0; r < M; r++) begin
         a[r] = 1'b0;
         for (int j = 0; j < K; j++) a[r] = a[r] ^ (H[j*M+r] & u[j]);
      end
      p[0] = a[0];
      for (int r = 1; r < M; r++) p[r] = a[r] ^ p[r-1];
      cw = '0;
      cw[K-1:0] = u;
      cw[N-1:K] = p;
      return cw;
   endfunction

   initial begin
      int n;
      logic [N-1:0]  cw, cwf;
      logic [K-1:0]  u;
      logic [M-1:0]  row, s_hold;
      logic [WW-1:0] w_hold;
      logic          seen;

      // Systematic H = [A | dual-diagonal], so the encoder above produces valid codewords.
      for (int j = 0; j < K; j++)
         for (int i = 0; i < M; i++) H[j*M+i] = ($urandom_range(3) == 0);
      for (int i = 0; i < M; i++) begin
         H[(K+i)*M+i] = 1'b1;
         if (i + 1 < M) H[(K+i)*M+i+1] = 1'b1;
      end

      #22 rst_n = 1'b1;
      tick();
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_cw_ok", 128'(cw_ok), 128'(0));

      // All-zero word: latency and clean result
      send('0);
      wait_valid("zero", n);
      chk("zero_latency", 128'(n), 128'(51));
      chk("zero_syn", 128'(syndrome), 128'(0));
      chk("zero_wt", 128'(syn_weight), 128'(0));
      chk("zero_ok", 128'(cw_ok), 128'(1));
      pop();

      // Encoded word passes; bit 203 flip gives H row 203 (a single bit 101 here)
      for (int j = 0; j < K; j++) u[j] = $urandom_range(1);
      cw = encode(u);
      chk("model_pin_valid", 128'(model_syn(cw, H)), 128'(0));
      send(cw);
      wait_valid("enc", n);
      chk("enc_ok", 128'(cw_ok), 128'(1));
      chk("enc_wt", 128'(syn_weight), 128'(0));
      pop();

      cwf = cw;
      cwf[203] = ~cwf[203];
      row = H[203*M +: M];
      send(cwf);
      wait_valid("flip203", n);
      chk("flip203_syn", 128'(syndrome), 128'(row));
      chk("flip203_syn_lit", 128'(syndrome), 128'(1) << 101);
      chk("flip203_wt", 128'(syn_weight), 128'(popc(row)));
      chk("flip203_ok", 128'(cw_ok), 128'(0));

      // Back-pressure: result held while out_ready is low
      s_hold = syndrome;
      w_hold = syn_weight;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("bp_valid", 128'(out_valid), 128'(1));
         chk("bp_in_ready", 128'(in_ready), 128'(0));
         chk("bp_syn", 128'(syndrome), 128'(s_hold));
         chk("bp_wt", 128'(syn_weight), 128'(w_hold));
      end
      pop();
      chk("bp_release_in_ready", 128'(in_ready), 128'(1));
      chk("bp_release_valid", 128'(out_valid), 128'(0));

      cwf = cw;
      cwf[0] = ~cwf[0];
      send(cwf);
      wait_valid("flip0", n);
      chk("flip0_syn", 128'(syndrome), 128'(H[0 +: M]));
      pop();

      // Padded small configuration: rows 001 ^ 111 = 110
      cw_in2 = 6'b100001;
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      chk("small_busy", 128'(busy2), 128'(1));
      chk("small_in_ready", 128'(in_ready2), 128'(0));
      tick();
      chk("small_valid_early", 128'(out_valid2), 128'(0));
      tick();
      chk("small_valid", 128'(out_valid2), 128'(1));
      chk("small_syn", 128'(syndrome2), 128'(3'b110));
      chk("small_wt", 128'(syn_weight2), 128'(2));
      chk("small_ok", 128'(cw_ok2), 128'(0));
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      chk("small_idle", 128'(in_ready2), 128'(1));

      // Flush at beat 20 aborts; a zero word afterwards is clean
      send(cwf);
      for (int c = 0; c < 20; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", 128'(busy), 128'(0));
      chk("flush_in_ready", 128'(in_ready), 128'(1));
      seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         seen = seen | out_valid;
      end
      chk("flush_no_valid", 128'(seen), 128'(0));
      flush = 1'b1;
      in_valid = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_blocks_accept", 128'(busy), 128'(0));
      send('0);
      wait_valid("post_flush", n);
      chk("post_flush_latency", 128'(n), 128'(51));
      chk("post_flush_ok", 128'(cw_ok), 128'(1));
      chk("post_flush_wt", 128'(syn_weight), 128'(0));
      pop();

      // Async reset mid-ACC
      send(cwf);
      for (int c = 0; c < 10; c++) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_acc_busy", 128'(busy), 128'(0));
      chk("rst_acc_in_ready", 128'(in_ready), 128'(1));
      chk("rst_acc_syn", 128'(syndrome), 128'(0));
      chk("rst_acc_ok", 128'(cw_ok), 128'(0));
      rst_n = 1'b1;
      tick();
      chk("rst_acc_after", 128'(in_ready), 128'(1));

      // Async reset mid-DONE
      send(cwf);
      wait_valid("pre_rst", n);
      chk("pre_rst_wt", 128'(syn_weight), 128'(popc(H[0 +: M])));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_done_valid", 128'(out_valid), 128'(0));
      chk("rst_done_syn", 128'(syndrome), 128'(0));
      chk("rst_done_wt", 128'(syn_weight), 128'(0));
      chk("rst_done_busy", 128'(busy), 128'(0));
      rst_n = 1'b1;
      tick();
      chk("rst_done_after", 128'(in_ready), 128'(1));
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/syndrome_check_seq.md
Name: syndrome_check_seq

Overview:
Sequential, parametrised LDPC syndrome checker. It computes s = cw·H^T over GF(2) across every codeword column, processing P columns per cycle, where the previous combinational checker covered only a fixed 6 columns. It reports the full syndrome, the syndrome weight and a pass flag through valid/ready handshakes. It sits after the hard-decision stage of the decoder and drives early-termination and iteration control.

Parameters:
N, 204, codeword length (columns of H)
K, 102, information length; M = N-K check rows
P, 4, columns processed per cycle, 1 <= P <= N; B = ceil(N/P) beats
WW, $clog2(N-K+1), width of syndrome weight output (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
H_t  in  N*M  flattened H transpose; codeword bit j maps to H_t[(j+1)*M-1 : j*M]; static while busy
in_valid  in  1  cw_in valid
in_ready  out  1  block can accept a codeword
cw_in  in  N  hard-decision codeword
flush  in  1  synchronous abort to IDLE
out_valid  out  1  result valid; held until taken
out_ready  in  1  consumer accepts result
syndrome  out  M  accumulated syndrome
syn_weight  out  WW  number of ones in syndrome
cw_ok  out  1  1 when syndrome == 0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE, beat counter 0, syndrome 0, syn_weight 0, cw_ok 0, out_valid 0, busy 0, cw register 0. in_ready is 1 after reset (combinational in IDLE).
- States: IDLE -> ACC -> DONE -> IDLE.
- IDLE: in_ready = 1. On in_valid: latch cw_in, clear syndrome accumulator, cnt = 0, go to ACC.
- ACC: in_ready = 0. Each edge: acc ^= XOR over p = 0..P-1 of (row(cnt*P+p) AND cw_reg[cnt*P+p]). Columns with index >= N contribute 0 (padding when N mod P != 0). cnt increments. On the beat with cnt = B-1: go to DONE and register syndrome, syn_weight = popcount(final acc), cw_ok = (final acc == 0), and out_valid = 1.
- Latency: out_valid rises exactly B edges after the accepting edge (B = 51 at defaults).
- DONE: outputs stay stable while out_valid=1 and out_ready=0. On out_ready: out_valid -> 0 and state -> IDLE. syndrome, syn_weight and cw_ok hold their last values until the next result.
- Throughput: one codeword per B+2 cycles minimum. in_ready is 0 in ACC and DONE.
- flush: highest priority over all synchronous events. On the next edge: state IDLE, out_valid 0, accumulator 0. Registered outputs are not otherwise cleared. If flush and in_valid are both asserted in IDLE, the codeword is not accepted.
- Async reset mid-ACC or mid-DONE discards the work in progress immediately.
- H_t changing while busy gives an undefined result; this is not checked.
- All XOR/AND is bitwise on M bits. No arithmetic overflow is possible. syn_weight <= M.

Test Plan:
- Defaults, cw_in = all zeros, in_valid for one cycle -> out_valid after exactly 51 edges; syndrome = 0, syn_weight = 0, cw_ok = 1.
- Defaults, known valid codeword from the encoder model -> cw_ok = 1, syn_weight = 0. Flip bit 203 -> syndrome equals H_t row 203, syn_weight equals popcount(row 203), cw_ok = 0.
- N=6, K=3, P=4 (B=2, padded beat), with rows H_t = {3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111} for j=0..5 and cw = 6'b100001 -> syndrome = 3'b110, syn_weight = 2, out_valid on the 2nd edge after accept.
- Back-pressure: hold out_ready = 0 for 10 cycles after out_valid -> outputs stable and in_ready = 0 throughout. Then out_ready = 1 for one cycle -> IDLE, in_ready = 1 on the next cycle.
- flush asserted at beat 20 of ACC -> out_valid never rises, IDLE next cycle. A new all-zero codeword then gives cw_ok = 1 with no residue from the aborted run.
- rst_n pulsed low asynchronously mid-ACC and mid-DONE -> all outputs immediately return to reset values, and in_ready = 1 after rst_n deasserts.
